// File: rtl/bcd_kpn_pkg.sv
// Shared types and constants for the BCD fixed-point add/sub KPN process.
package bcd_kpn_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FRAC  = 2'd1,
        S_INT   = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [4:0] BCD_TEN  = 5'd10;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/bcd_fixed_addsub_kpn_if.sv
// KPN channel bundle: two FWFT input FIFOs, one output FIFO, operation select.
interface bcd_fixed_addsub_kpn_if #(
    parameter int W = 16
);
    logic [W-1:0] in1_data;
    logic         in1_empty;
    logic         rd_1;
    logic [W-1:0] in2_data;
    logic         in2_empty;
    logic         rd_2;
    logic         op_sub;
    logic [W-1:0] out_data;
    logic         out_full;
    logic         wr;

    // The process side: consumes tokens, produces results.
    modport slave (
        input  in1_data, in1_empty, in2_data, in2_empty, op_sub, out_full,
        output rd_1, rd_2, out_data, wr
    );

    // The environment side: FIFOs and operation control.
    modport master (
        output in1_data, in1_empty, in2_data, in2_empty, op_sub, out_full,
        input  rd_1, rd_2, out_data, wr
    );
endinterface

// File: rtl/bcd_digit_addsub.sv
// One BCD digit add or subtract with carry/borrow; out-of-range digits clamp to 9.
module bcd_digit_addsub
    import bcd_kpn_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       sub,
    output logic [3:0] d,
    output logic       cout,
    output logic       clamped
);
    logic [3:0] a_c;
    logic [3:0] b_c;
    logic [4:0] sum;
    logic [4:0] rhs;
    logic [4:0] tmp;

    // Clamp, then add with decimal carry or subtract with decimal borrow.
    always_comb begin
        a_c     = (a > BCD_NINE) ? BCD_NINE : a;
        b_c     = (b > BCD_NINE) ? BCD_NINE : b;
        clamped = (a > BCD_NINE) || (b > BCD_NINE);
        sum     = {1'b0, a_c} + {1'b0, b_c} + {4'b0, cin};
        rhs     = {1'b0, b_c} + {4'b0, cin};
        tmp     = sum;
        cout    = 1'b0;
        if (sub == OP_SUB) begin
            if ({1'b0, a_c} < rhs) begin
                tmp  = ({1'b0, a_c} + BCD_TEN) - rhs;
                cout = 1'b1;
            end else begin
                tmp  = {1'b0, a_c} - rhs;
            end
        end else if (sum >= BCD_TEN) begin
            tmp  = sum - BCD_TEN;
            cout = 1'b1;
        end
        d = tmp[3:0];
    end
endmodule

// File: rtl/bcd_fixed_addsub_kpn.sv
// Digit-serial BCD fixed-point add/sub KPN process with saturation and
// blocking FIFO handshakes on both inputs and the output.
module bcd_fixed_addsub_kpn
    import bcd_kpn_pkg::*;
#(
    parameter int INT_W       = 12,
    parameter int FRAC_DIGITS = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bcd_fixed_addsub_kpn_if.slave  bus,
    output logic                   ovf,
    output logic                   unf,
    output logic                   bad_digit,
    output logic                   busy
);
    localparam int W     = INT_W + 4 * FRAC_DIGITS;
    localparam int FW    = 4 * FRAC_DIGITS;
    localparam int IDX_W = (FRAC_DIGITS > 1) ? $clog2(FRAC_DIGITS) : 1;

    state_t             state_reg;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic               sub_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               carry_reg;
    logic [FW-1:0]      frac_reg;
    logic [W-1:0]       out_reg;

    logic               pop;
    logic               last_digit;
    logic [3:0]         dig_d;
    logic               dig_cout;
    logic               dig_clamped;
    logic [FW-1:0]      frac_nines;
    logic [INT_W-1:0]   a_int;
    logic [INT_W-1:0]   b_int;
    logic [INT_W:0]     int_add;
    logic [INT_W:0]     int_sub;
    logic [INT_W:0]     int_res;

    // Both channels pop together, and only when both hold a token.
    assign pop         = (state_reg == S_IDLE) && !bus.in1_empty && !bus.in2_empty;
    assign bus.rd_1    = pop;
    assign bus.rd_2    = pop;
    assign bus.wr      = (state_reg == S_WRITE) && !bus.out_full;
    assign bus.out_data = out_reg;
    assign busy        = (state_reg != S_IDLE);
    assign last_digit  = (idx_reg == IDX_W'(FRAC_DIGITS - 1));

    // Saturated fraction: every digit is nine.
    generate
        for (genvar gi = 0; gi < FRAC_DIGITS; gi++) begin : g_nines
            assign frac_nines[4*gi +: 4] = BCD_NINE;
        end
    endgenerate

    // Single digit slice, walked across the fraction one digit per cycle.
    bcd_digit_addsub u_digit (
        .a       (a_reg[4*int'(idx_reg) +: 4]),
        .b       (b_reg[4*int'(idx_reg) +: 4]),
        .cin     (carry_reg),
        .sub     (sub_reg),
        .d       (dig_d),
        .cout    (dig_cout),
        .clamped (dig_clamped)
    );

    // Integer part with the fraction carry folded in; the top bit is carry/borrow out.
    assign a_int   = a_reg[W-1:FW];
    assign b_int   = b_reg[W-1:FW];
    assign int_add = {1'b0, a_int} + {1'b0, b_int} + {{INT_W{1'b0}}, carry_reg};
    assign int_sub = {1'b0, a_int} - {1'b0, b_int} - {{INT_W{1'b0}}, carry_reg};
    assign int_res = (sub_reg == OP_SUB) ? int_sub : int_add;

    // Sequencer: pop, fraction digits, integer/saturation, blocking write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sub_reg   <= OP_ADD;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            frac_reg  <= '0;
            out_reg   <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            bad_digit <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (pop) begin
                        a_reg     <= bus.in1_data;
                        b_reg     <= bus.in2_data;
                        sub_reg   <= bus.op_sub;
                        idx_reg   <= '0;
                        carry_reg <= 1'b0;
                        state_reg <= S_FRAC;
                    end
                end
                S_FRAC: begin
                    frac_reg[4*int'(idx_reg) +: 4] <= dig_d;
                    carry_reg <= dig_cout;
                    if (dig_clamped) begin
                        bad_digit <= 1'b1;
                    end
                    if (last_digit) begin
                        state_reg <= S_INT;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                S_INT: begin
                    if (int_res[INT_W]) begin
                        if (sub_reg == OP_SUB) begin
                            out_reg <= '0;
                            unf     <= 1'b1;
                        end else begin
                            out_reg <= {{INT_W{1'b1}}, frac_nines};
                            ovf     <= 1'b1;
                        end
                    end else begin
                        out_reg <= {int_res[INT_W-1:0], frac_reg};
                    end
                    state_reg <= S_WRITE;
                end
                S_WRITE: begin
                    if (!bus.out_full) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/bcd_fixed_addsub_kpn.md
Name: bcd_fixed_addsub_kpn

Overview:
- Parametrised successor of the KPN fixed-point adder process.
- Operand format: unsigned INT_W-bit binary integer part plus FRAC_DIGITS BCD fractional digits.
- Performs add or subtract, digit-serial, with saturation.
- Talks to KPN FIFO channels through real blocking-read / blocking-write handshakes instead of clock-derived rd/wr.

Parameters:
INT_W, 12, integer-part width in bits (>=2)
FRAC_DIGITS, 1, number of BCD fractional digits (>=1)
W, INT_W+4*FRAC_DIGITS (derived, localparam), token width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in1_data  in  W  channel-1 head token (first-word-fall-through)
in1_empty  in  1  channel-1 FIFO empty
rd_1  out  1  pop channel 1
in2_data  in  W  channel-2 head token
in2_empty  in  1  channel-2 FIFO empty
rd_2  out  1  pop channel 2
op_sub  in  1  0=add, 1=subtract (in1-in2); sampled on pop
out_data  out  W  result token
out_full  in  1  output FIFO full
wr  out  1  push out_data
ovf  out  1  sticky: an add saturated
unf  out  1  sticky: a subtract clamped to zero
bad_digit  out  1  sticky: an input fraction digit was >9
busy  out  1  state != S_IDLE

Behaviour:
- Clock is clk; reset is asynchronous and active-low (rst_n). Reset forces state S_IDLE, out_data=0, ovf=unf=bad_digit=0, digit index=0, carry=0. rd_1/rd_2/wr/busy are then 0 because they decode from state.
- Token layout: [W-1:4*FRAC_DIGITS] integer; digit k at [4k+3:4k], k=0 least significant.
- S_IDLE:
  - rd_1 = rd_2 = !in1_empty && !in2_empty (combinational, same cycle). Both pop together, never one alone.
  - On pop: latch in1_data, in2_data and op_sub; idx=0, carry=0; go to S_FRAC.
- S_FRAC: one digit per cycle, idx 0 upward.
  - Digits >9 are clamped to 9 and set bad_digit.
  - add: s=a+b+c; if s>=10 then s-=10, c=1, else c=0.
  - sub: s=a-b-c; if s<0 then s+=10, c=1 (borrow), else c=0.
  - Store digit idx; at idx==FRAC_DIGITS-1 go to S_INT.
- S_INT: integer computed in INT_W+1 bits as a±b±c.
  - Add carry-out: result saturates to integer all-ones with all fraction digits 9; set ovf.
  - Sub borrow-out: result forced to 0; set unf.
  - Register out_data; go to S_WRITE.
- S_WRITE: wr = !out_full (combinational).
  - out_data is held stable while in S_WRITE.
  - On wr=1, go to S_IDLE; while full, stay (blocking write) with no pops.
- Latency: pop in cycle T; wr can first assert in cycle T+FRAC_DIGITS+2. Maximum throughput is one token per FRAC_DIGITS+3 cycles.
- Simultaneous events: one input empty means no pop of either channel. out_full only matters in S_WRITE.
- Reset mid-operation: the popped token is discarded; no partial write ever occurs.
- Sticky flags clear only on reset.

Decomposition:
- Package bcd_kpn_pkg: state enum (S_IDLE, S_FRAC, S_INT, S_WRITE), BCD_NINE=4'd9, BCD_TEN=5'd10, op encodings.
- Sub-module bcd_digit_addsub: combinational one-digit add/sub. Inputs a[3:0], b[3:0], cin, sub; outputs d[3:0], cout, clamped. Instanced once and reused per cycle.

Test Plan:
- Defaults, 12.5+3.7: in1=16'h00C5, in2=16'h0037, op_sub=0 -> out_data=16'h0102. wr exactly 3 cycles after the pop; flags stay 0.
- Defaults, 5.3-2.8: 16'h0053 - 16'h0028 -> 16'h0025. Then 1.0-2.0: 16'h0010 - 16'h0020 -> 16'h0000, unf=1.
- Overflow, 4095.9+0.1: 16'hFFF9 + 16'h0001 -> 16'hFFF9, ovf=1. A following 1.0+1.0 -> 16'h0020 with ovf still 1.
- Handshake: hold in2_empty=1 for 4 cycles -> rd_1=rd_2=0 throughout. Then out_full=1 for 5 cycles in S_WRITE -> wr=0, out_data stable, no pops; wr pulses when full drops.
- INT_W=8, FRAC_DIGITS=2, 1.99+0.01: 16'h0199 + 16'h0001 -> 16'h0200, latency 4. A digit 4'hC in any input -> bad_digit=1.
- Reset: drive rst_n=0 asynchronously during S_FRAC -> immediate S_IDLE, out_data=0, no wr. After release, the next token is processed normally.
